// File: rtl/waveform_generator.sv
// -----------------------------------------------------------------------------
// waveform_generator
//
// Multi-mode periodic waveform source that feeds the PWM comparator. A
// free-running prescaler produces one tick every 2^PW enabled cycles. A
// programmable step divider turns every scale_eff ticks into one phase step.
// A DW-bit phase accumulator is then shaped into one of four waveforms and
// registered onto duty_out.
//
// Parameters:
//   DW  duty/phase width in bits (>= 2)
//   PW  prescaler width; one tick every 2^PW enabled cycles
//   SW  width of the scale input
//
// Ports:
//   sysclk        in   1   system clock, all state on the rising edge
//   rst_n         in   1   asynchronous active-low reset
//   enable        in   1   run/stop; low clears the counters and forces 0 out
//   mode          in   2   00 saw up, 01 saw down, 10 triangle, 11 square
//   scale         in   SW  ticks per phase step (0 behaves as 1)
//   duty_out      out  DW  registered waveform sample
//   period_start  out  1   one-cycle strobe while duty_out shows phase 0
// -----------------------------------------------------------------------------
module waveform_generator #(
    parameter int DW = 7,
    parameter int PW = 6,
    parameter int SW = 6
) (
    input  logic          sysclk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [SW-1:0] scale,
    output logic [DW-1:0] duty_out,
    output logic          period_start
);

    localparam logic [1:0] MODE_SAW_UP   = 2'b00;
    localparam logic [1:0] MODE_SAW_DOWN = 2'b01;
    localparam logic [1:0] MODE_TRIANGLE = 2'b10;
    localparam logic [1:0] MODE_SQUARE   = 2'b11;

    logic [PW-1:0] r_pre;
    logic [SW-1:0] r_stp;
    logic [DW-1:0] r_phase;
    logic [DW-1:0] r_prev_phase;
    logic [DW-1:0] r_duty;
    logic          r_period_start;

    logic          w_tick;
    logic [SW-1:0] w_scale_eff;
    logic          w_step;
    logic [DW-1:0] w_shape;
    logic [DW-1:0] w_tri_ramp;
    logic          w_wrap;

    assign w_tick      = enable & (r_pre == {PW{1'b1}});
    assign w_scale_eff = (scale == '0) ? SW'(1) : scale;
    // ">=" rather than "==": if scale shrinks below the running count, the
    // step fires on the next tick instead of waiting for stp to wrap.
    assign w_step      = w_tick & (r_stp >= (w_scale_eff - SW'(1)));

    // Triangle: phase doubled (MSB dropped) rises over the first half and is
    // inverted over the second half, so each ramp spans half the period.
    assign w_tri_ramp  = {r_phase[DW-2:0], 1'b0};

    // Phase has just wrapped to 0 from a non-zero value. prev_phase is cleared
    // while disabled, so the restart from phase 0 does not strobe.
    assign w_wrap      = (r_phase == '0) & (r_prev_phase != '0);

    always_comb begin
        w_shape = r_phase;
        case (mode)
            MODE_SAW_UP:   w_shape = r_phase;
            MODE_SAW_DOWN: w_shape = ~r_phase;
            MODE_TRIANGLE: w_shape = r_phase[DW-1] ? ~w_tri_ramp : w_tri_ramp;
            MODE_SQUARE:   w_shape = {DW{~r_phase[DW-1]}};
            default:       w_shape = r_phase;
        endcase
    end

    // Counters: a low enable clears everything, winning over a same-cycle tick.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre        <= '0;
            r_stp        <= '0;
            r_phase      <= '0;
            r_prev_phase <= '0;
        end else if (!enable) begin
            r_pre        <= '0;
            r_stp        <= '0;
            r_phase      <= '0;
            r_prev_phase <= '0;
        end else begin
            r_pre        <= r_pre + PW'(1);
            r_prev_phase <= r_phase;
            if (w_step) begin
                r_stp   <= '0;
                r_phase <= r_phase + DW'(1);
            end else if (w_tick) begin
                r_stp   <= r_stp + SW'(1);
            end
        end
    end

    // Output registers: one cycle behind phase, so duty and strobe line up.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty         <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_duty         <= enable ? w_shape : '0;
            r_period_start <= enable & w_wrap;
        end
    end

    assign duty_out     = r_duty;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_waveform_generator.sv
// -----------------------------------------------------------------------------
// tb_waveform_generator
//
// Directed scenarios from the test plan followed by a randomized run, all
// checked against an arithmetic model of the waveform rules.
// -----------------------------------------------------------------------------
module tb_waveform_generator;

    localparam int DW   = 4;
    localparam int PW   = 2;
    localparam int SW   = 6;
    localparam int NPH  = 1 << DW;
    localparam int NPRE = 1 << PW;
    localparam int MAXV = NPH - 1;
    localparam int HALF = NPH / 2;

    logic          sysclk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [1:0]    mode;
    logic [SW-1:0] scale;
    logic [DW-1:0] duty_out;
    logic          period_start;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: {period_start, duty_out} expected after each edge.
    logic [DW:0] exp_q[$];

    // Model state, in plain integers.
    int m_cyc;    // enabled cycles since last restart
    int m_stp;    // ticks counted towards the next step
    int m_phase;  // current phase, 0 .. NPH-1
    int m_prev;   // phase one cycle ago (0 after restart)

    int cyc_cnt;
    int first_ps;
    int ps_count;

    waveform_generator #(.DW(DW), .PW(PW), .SW(SW)) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .scale        (scale),
        .duty_out     (duty_out),
        .period_start (period_start)
    );

    // ---------------- clock ----------------
    always #5 sysclk = ~sysclk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int shape(input int ph, input logic [1:0] md);
        case (md)
            2'd0: shape = ph;
            2'd1: shape = MAXV - ph;
            2'd2: shape = (ph < HALF) ? 2 * ph : MAXV - 2 * (ph - HALF);
            default: shape = (ph < HALF) ? MAXV : 0;
        endcase
    endfunction

    task automatic model_reset();
        m_cyc   = 0;
        m_stp   = 0;
        m_phase = 0;
        m_prev  = 0;
    endtask

    // One rising edge of the model, using the inputs currently driven.
    task automatic model_edge();
        logic [DW-1:0] e_duty;
        logic          e_ps;
        int            eff;
        if (!enable) begin
            model_reset();
            e_duty = '0;
            e_ps   = 1'b0;
        end else begin
            e_duty = DW'(shape(m_phase, mode));
            e_ps   = (m_phase == 0) && (m_prev != 0);
            m_prev = m_phase;
            eff    = (scale == 0) ? 1 : int'(scale);
            if ((m_cyc % NPRE) == NPRE - 1) begin
                if (m_stp >= eff - 1) begin
                    m_stp   = 0;
                    m_phase = (m_phase + 1) % NPH;
                end else begin
                    m_stp = m_stp + 1;
                end
            end
            m_cyc = m_cyc + 1;
        end
        exp_q.push_back({e_ps, e_duty});
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock: model at the rising edge, compare at the falling edge.
    // Callers change inputs right after this returns (falling edge).
    task automatic do_cycle();
        logic [DW:0] e;
        @(posedge sysclk);
        model_edge();
        @(negedge sysclk);
        cyc_cnt++;
        e = exp_q.pop_front();
        check("duty", 32'(duty_out), 32'(e[DW-1:0]));
        check("pstart", 32'(period_start), 32'(e[DW]));
        if (period_start) begin
            ps_count++;
            if (first_ps < 0) first_ps = cyc_cnt;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    // Pulse rst_n low between edges; outputs must clear without a clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_duty", 32'(duty_out), 32'd0);
        check("rst_pstart", 32'(period_start), 32'd0);
        exp_q.delete();
        model_reset();
        @(negedge sysclk);
        @(negedge sysclk);
        rst_n    = 1'b1;
        cyc_cnt  = 0;
        first_ps = -1;
        ps_count = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        int gap;
        logic [DW-1:0] last;

        rst_n    = 1'b0;
        enable   = 1'b1;
        mode     = 2'd0;
        scale    = SW'(3);
        cyc_cnt  = 0;
        first_ps = -1;
        ps_count = 0;
        model_reset();
        #12;
        check("reset_duty", 32'(duty_out), 32'd0);
        check("reset_pstart", 32'(period_start), 32'd0);
        @(negedge sysclk);
        rst_n = 1'b1;

        // Saw up, scale 3: one step per 12 cycles, wrap after 192 cycles.
        run(400);
        check("first_strobe_cycle", 32'(first_ps), 32'd193);
        check("strobe_count", 32'(ps_count), 32'd2);

        // Triangle then square over a full period each.
        mode = 2'd2;
        run(200);
        mode = 2'd3;
        run(200);
        mode = 2'd1;
        run(60);

        // scale 0 behaves as 1: first step after 4 cycles, visible at cycle 5.
        mode  = 2'd0;
        scale = '0;
        async_reset();
        run(5);
        check("scale0_first_step", 32'(duty_out), 32'd1);
        run(70);
        scale = SW'(1);
        run(70);

        // Shrink scale 5 -> 2 while stp is 4: step on next tick, then every 8.
        scale = SW'(5);
        guard = 0;
        while (m_stp != 4 && guard < 200) begin
            do_cycle();
            guard++;
        end
        check("wait_stp4_timeout", 32'(guard < 200), 32'd1);
        scale = SW'(2);
        last  = duty_out;
        guard = 0;
        while (duty_out == last && guard < 10) begin
            do_cycle();
            guard++;
        end
        check("shrink_next_tick", 32'(guard <= 5), 32'd1);
        last = duty_out;
        gap  = 0;
        while (duty_out == last && gap < 20) begin
            do_cycle();
            gap++;
        end
        check("shrink_step_gap", 32'(gap), 32'd8);

        // Drop enable at phase 9, then restart from phase 0 without a strobe.
        scale = SW'(1);
        guard = 0;
        while (m_phase != 9 && guard < 200) begin
            do_cycle();
            guard++;
        end
        check("wait_phase9_timeout", 32'(guard < 200), 32'd1);
        enable = 1'b0;
        do_cycle();
        check("disable_duty", 32'(duty_out), 32'd0);
        enable = 1'b1;
        do_cycle();
        check("reenable_duty", 32'(duty_out), 32'd0);
        check("reenable_pstart", 32'(period_start), 32'd0);
        run(100);

        // Async reset mid-ramp, then a restart from the reset state.
        scale = SW'(3);
        run(50);
        async_reset();
        run(200);

        // Randomized mix of mode, scale, enable drops and one async reset.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) scale = SW'($urandom_range(0, 7));
            if (enable == 1'b0) begin
                if ($urandom_range(0, 2) == 0) enable = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                enable = 1'b0;
            end
            if (i == 1300) begin
                enable = 1'b1;
                async_reset();
            end
            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
